pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register that generalises the fixed PC/instruction latch between pipeline stages. It carries a WIDTH-bit payload with a valid/ready handshake, flush that inserts a bubble, a saturating stall counter, and an optional 2-entry skid buffer that breaks the combinational ready path. It sits between any two CPU pipeline stages (IF/ID, ID/EX, …), replacing per-stage hand-written latches.

## Interface

Parameters:

- WIDTH, 64, payload width in bits; e.g. {PC, inst}.
- BUBBLE, {WIDTH{1'b0}}, value driven on out_data_o whenever out_valid_o=0 (flushed/empty NOP).
- CNT_W, 16, width of the stall counter.

Ports:

- clk_i, in, 1, sole clock; all state updates on the rising edge.
- rst_i, in, 1, synchronous, active-low reset.
- in_valid_i, in, 1, upstream beat present.
- in_ready_o, out, 1, stage can accept a beat this cycle.
- in_data_i, in, WIDTH, upstream payload.
- flush_i, in, 1, discard all held and incoming beats.
- out_valid_o, out, 1, downstream beat present.
- out_ready_i, in, 1, downstream accepts.
- out_data_o, out, WIDTH, payload, or BUBBLE when not valid.
- occupancy_o, out, 2, entries held (0..2).
- stall_cnt_o, out, CNT_W, saturating count of back-pressured cycles.

## Operation

- Accept: in_valid_i && in_ready_o. Emit: out_valid_o && out_ready_i.
- Order is strictly FIFO; no beat is duplicated or dropped except by flush.
- Main register holds the head entry and drives out_data_o directly (registered output). When out_valid_o=0, out_data_o=BUBBLE.
- Flush: when flush_i=1 at an edge, all entries are cleared, any beat accepted that cycle is discarded, and the counter is unaffected. Next cycle: occupancy_o=0, out_valid_o=0, out_data_o=BUBBLE. Flush overrides simultaneous accept/emit; an emit in the flush cycle still counts as delivered downstream.
- Skid-buffer state machine, states EMPTY/ONE/TWO, occupancy_o equal to the state:
  - EMPTY: accept→ONE.
  - ONE: accept&&emit→ONE (main reloads); accept only→TWO (beat goes to skid); emit only→EMPTY.
  - TWO: emit→ONE (skid moves to main). No accept is possible.
- stall_cnt_o increments on every cycle with out_valid_o && !out_ready_i and saturates at 2^CNT_W−1 (no wrap).
- Reset (rst_i=0 at an edge, overrides everything, including mid-transfer): state EMPTY, out_valid_o=0, out_data_o=BUBBLE, occupancy_o=0, stall_cnt_o=0. in_ready_o=1 the cycle after reset.

## Timing

- Latency: a beat accepted at edge N is visible on out_valid_o/out_data_o after edge N. That is 1 cycle, with no combinational in→out data path.
- Throughput: 1 beat/cycle while out_ready_i=1.
- With PIPE_STAGE_SKID_EN, in_ready_o = (state != TWO), a pure register output.
- Without PIPE_STAGE_SKID_EN, in_ready_o = !out_valid_o || out_ready_i, which is combinational from out_ready_i.
- flush_i and rst_i are sampled only at the edge. in_ready_o does not depend on flush_i.

## Configuration

- PIPE_STAGE_SKID_EN defined: 2-entry skid buffer and the EMPTY/ONE/TWO FSM; occupancy_o ranges 0..2; in_ready_o is registered.
- PIPE_STAGE_SKID_EN undefined: single entry with states EMPTY/ONE only; occupancy_o ∈ {0,1}; in_ready_o is combinational as above. All other behaviour is identical.

## Test plan

- Reset: hold rst_i=0 for 2 cycles with in_valid_i=1 and data 0xDEAD → out_valid_o=0, out_data_o=BUBBLE, stall_cnt_o=0, occupancy_o=0. After release, in_ready_o=1.
- Streaming: 8 beats 0x1..0x8 with out_ready_i=1 → outputs 0x1..0x8 on consecutive cycles, each 1 cycle after acceptance, occupancy_o=1 throughout.
- Back-pressure (skid on): out_ready_i=0 while pushing 0xA, 0xB, 0xC → 0xA and 0xB are accepted, occupancy_o=2, in_ready_o=0, and 0xC is held upstream. stall_cnt_o increments each stalled cycle. Then release → 0xA, 0xB, 0xC delivered in order.
- Flush: with occupancy_o=2, assert flush_i for one cycle while pushing 0xE → next cycle out_valid_o=0, out_data_o=BUBBLE, occupancy_o=0. 0xE never appears downstream.
- Saturation: with CNT_W=4, hold out_ready_i=0 with a valid beat for 20 cycles → stall_cnt_o stops at 15.
- Skid off: same back-pressure as the third test → only 0xA is accepted. in_ready_o follows out_ready_i in the same cycle while full.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic pipeline stage register with a valid/ready
// handshake, flush-to-bubble, a saturating stall counter and an optional
// 2-entry skid buffer.
//
// Build option:
//   PIPE_STAGE_SKID_EN defined   -> 2-entry skid buffer (EMPTY/ONE/TWO),
//                                   in_ready_o comes straight from state.
//   PIPE_STAGE_SKID_EN undefined -> single entry (EMPTY/ONE), in_ready_o is
//                                   combinational from out_ready_i.
//
// The head entry lives in main_q, which drives out_data_o directly. main_q
// is reloaded with BUBBLE whenever the stage goes empty, so the output is
// always a plain register and shows BUBBLE while out_valid_o is low.

module pipe_stage_reg #(
  parameter int unsigned      WIDTH  = 64,
  parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}},
  parameter int unsigned      CNT_W  = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [1:0]       occupancy_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  // State encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
`ifdef PIPE_STAGE_SKID_EN
  logic [WIDTH-1:0] skid_q, skid_d;
`endif

  logic out_valid;
  logic in_ready;
  logic accept;
  logic emit;
  logic stalled;

  // Handshake qualifiers derived from the current state and the ready inputs.
  always_comb begin
    out_valid = (state_q != ST_EMPTY);
`ifdef PIPE_STAGE_SKID_EN
    in_ready  = (state_q != ST_TWO);
`else
    in_ready  = !out_valid || out_ready_i;
`endif
    accept    = in_valid_i && in_ready;
    emit      = out_valid && out_ready_i;
    stalled   = out_valid && !out_ready_i;
  end

  assign out_valid_o = out_valid;
  assign in_ready_o  = in_ready;
  assign out_data_o  = main_q;
  assign occupancy_o = state_q;
  assign stall_cnt_o = stall_cnt_q;

  // Next-state and datapath steering; flush wins over any accept/emit.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
`ifdef PIPE_STAGE_SKID_EN
    skid_d  = skid_q;
`endif

    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_ONE;
          main_d  = in_data_i;
        end
      end

      ST_ONE: begin
`ifdef PIPE_STAGE_SKID_EN
        if (accept && emit) begin
          main_d = in_data_i;
        end else if (accept) begin
          state_d = ST_TWO;
          skid_d  = in_data_i;
        end else if (emit) begin
          state_d = ST_EMPTY;
          main_d  = BUBBLE;
        end
`else
        // Without the skid, an accept while full implies a same-cycle emit.
        if (accept) begin
          main_d = in_data_i;
        end else if (emit) begin
          state_d = ST_EMPTY;
          main_d  = BUBBLE;
        end
`endif
      end

      ST_TWO: begin
`ifdef PIPE_STAGE_SKID_EN
        if (emit) begin
          state_d = ST_ONE;
          main_d  = skid_q;
          skid_d  = BUBBLE;
        end
`else
        state_d = ST_EMPTY;
        main_d  = BUBBLE;
`endif
      end

      default: begin
        state_d = ST_EMPTY;
        main_d  = BUBBLE;
      end
    endcase

    if (flush_i) begin
      state_d = ST_EMPTY;
      main_d  = BUBBLE;
`ifdef PIPE_STAGE_SKID_EN
      skid_d  = BUBBLE;
`endif
    end
  end

  // Stall counter: count back-pressured cycles, stick at the maximum.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stalled && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  // State, payload and counter registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= ST_EMPTY;
      main_q      <= BUBBLE;
      stall_cnt_q <= '0;
`ifdef PIPE_STAGE_SKID_EN
      skid_q      <= BUBBLE;
`endif
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      stall_cnt_q <= stall_cnt_d;
`ifdef PIPE_STAGE_SKID_EN
      skid_q      <= skid_d;
`endif
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: directed scenarios followed by random
// traffic, all checked against a queue-based model of the stage.
module tb_pipe_stage_reg;

  localparam int unsigned      WIDTH  = 16;
  localparam logic [WIDTH-1:0] BUBBLE = 16'h0B0B;
  localparam int unsigned      CNT_W  = 4;
  localparam int               CMAX   = 15;
`ifdef PIPE_STAGE_SKID_EN
  localparam int               CAP    = 2;
`else
  localparam int               CAP    = 1;
`endif

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] stall_cnt;

  pipe_stage_reg #(
    .WIDTH (WIDTH),
    .BUBBLE(BUBBLE),
    .CNT_W (CNT_W)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .flush_i    (flush),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .occupancy_o(occupancy),
    .stall_cnt_o(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the stage is a FIFO of at most CAP beats.
  logic [WIDTH-1:0] mq[$];
  int               mcnt;
  bit               known;
  int               total;
  int               bad;
  logic [WIDTH-1:0] src[$];
  bit               acc_flag;

  task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input logic rdy);
    logic             e_valid;
    logic [WIDTH-1:0] e_data;
    logic             e_ready;
    e_valid = (mq.size() > 0);
    e_data  = e_valid ? mq[0] : BUBBLE;
    e_ready = (CAP == 2) ? (mq.size() < 2) : ((mq.size() == 0) || rdy);
    check1("out_valid", {31'd0, out_valid}, {31'd0, e_valid});
    check1("out_data", {16'd0, out_data}, {16'd0, e_data});
    check1("occupancy", {30'd0, occupancy}, mq.size());
    check1("in_ready", {31'd0, in_ready}, {31'd0, e_ready});
    check1("stall_cnt", {28'd0, stall_cnt}, mcnt);
  endtask

  // One clock cycle: drive inputs, check outputs, then advance the model.
  task automatic applyStimulus(input logic rst, input logic v, input logic [WIDTH-1:0] d,
                               input logic fl, input logic rdy, output bit accepted);
    logic e_ready;
    logic acc;
    logic em;
    @(negedge clk);
    rst_n     = rst;
    in_valid  = v;
    in_data   = d;
    flush     = fl;
    out_ready = rdy;
    #1;
    if (known) checkOutput(rdy);
    e_ready  = (CAP == 2) ? (mq.size() < 2) : ((mq.size() == 0) || rdy);
    acc      = v && e_ready;
    em       = (mq.size() > 0) && rdy;
    accepted = 1'b0;
    @(posedge clk);
    if (!rst) begin
      mq.delete();
      mcnt  = 0;
      known = 1'b1;
    end else if (known) begin
      accepted = acc;
      if ((mq.size() > 0) && !rdy && (mcnt < CMAX)) mcnt++;
      if (fl) begin
        mq.delete();
      end else begin
        if (em) void'(mq.pop_front());
        if (acc) mq.push_back(d);
      end
    end
  endtask

  // Feed the upstream source queue for n cycles with a fixed downstream ready.
  task automatic run_src(input int n, input logic rdy);
    for (int i = 0; i < n; i++) begin
      if (src.size() > 0) begin
        applyStimulus(1'b1, 1'b1, src[0], 1'b0, rdy, acc_flag);
        if (acc_flag) void'(src.pop_front());
      end else begin
        applyStimulus(1'b1, 1'b0, 16'h5555, 1'b0, rdy, acc_flag);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    mcnt  = 0;
    known = 1'b0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;

    // Reset held two cycles with a valid beat present.
    applyStimulus(1'b0, 1'b1, 16'hDEAD, 1'b0, 1'b0, acc_flag);
    applyStimulus(1'b0, 1'b1, 16'hDEAD, 1'b0, 1'b0, acc_flag);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, acc_flag);

    // Streaming 0x1..0x8 with downstream always ready.
    for (int i = 1; i <= 8; i++) src.push_back(WIDTH'(i));
    run_src(11, 1'b1);

    // Back-pressure: push A, B, C while blocked, then release.
    src.push_back(16'h000A); src.push_back(16'h000B); src.push_back(16'h000C);
    run_src(4, 1'b0);
    run_src(5, 1'b1);

    // Flush while full, with 0xE offered upstream.
    src.push_back(16'h0011); src.push_back(16'h0012);
    run_src(3, 1'b0);
    src.delete();
    applyStimulus(1'b1, 1'b1, 16'h000E, 1'b1, 1'b0, acc_flag);
    run_src(2, 1'b1);

    // Flush on a cycle where a beat is both emitted and accepted.
    applyStimulus(1'b1, 1'b1, 16'h0021, 1'b0, 1'b1, acc_flag);
    applyStimulus(1'b1, 1'b1, 16'h000E, 1'b1, 1'b1, acc_flag);
    run_src(2, 1'b1);

    // Counter saturation: a valid beat blocked for 20 cycles.
    src.push_back(16'h0077);
    run_src(21, 1'b0);
    run_src(3, 1'b1);

    // Reset in the middle of a stalled transfer.
    src.push_back(16'h0031); src.push_back(16'h0032);
    run_src(3, 1'b0);
    src.delete();
    applyStimulus(1'b0, 1'b1, 16'h0033, 1'b0, 1'b0, acc_flag);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, acc_flag);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) != 0),
                    WIDTH'($urandom), ($urandom_range(0, 15) == 0),
                    ($urandom_range(0, 2) != 0), acc_flag);
    end
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, acc_flag);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
